param_universal_shiftreg: RTL and testbench

PARAM_UNIVERSAL_SHIFTREG -- requirements
Module: param_universal_shiftreg

---
 rtl/param_universal_shiftreg.sv | 137 +++++++++++++
 tb/tb_param_universal_shiftreg.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_universal_shiftreg.sv
// Universal shift register: hold/shift/load/rotate/arith-shift, run as N single-bit steps by a
// small IDLE/SHIFT/DONE sequencer. Define SHIFTREG_ROTATE_EN to build the rotate modes.
module param_universal_shiftreg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] in,
  input  logic             rightshift,
  input  logic             leftshift,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ModeShl  = 3'b001;
  localparam logic [2:0] ModeShr  = 3'b010;
  localparam logic [2:0] ModeLoad = 3'b011;
`ifdef SHIFTREG_ROTATE_EN
  localparam logic [2:0] ModeRol  = 3'b100;
  localparam logic [2:0] ModeRor  = 3'b101;
`endif
  localparam logic [2:0] ModeAsr  = 3'b110;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             sout_q, sout_d;
  logic             step_mode;

  // Modes that run through SHIFT; everything else (incl. disabled rotates) is a hold.
  always_comb begin
    step_mode = 1'b0;
    unique case (mode)
      ModeShl, ModeShr, ModeAsr: step_mode = 1'b1;
`ifdef SHIFTREG_ROTATE_EN
      ModeRol, ModeRor:          step_mode = 1'b1;
`endif
      default:                   step_mode = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    sout_d  = sout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (mode == ModeLoad) begin
            out_d   = in;
            state_d = StDone;
          end else if (step_mode && (amount != '0)) begin
            mode_d  = mode;
            cnt_d   = amount;
            state_d = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: begin
        // Serial inputs are sampled live here, not latched at start.
        unique case (mode_q)
          ModeShl: begin
            out_d  = {out_q[WIDTH-2:0], leftshift};
            sout_d = out_q[WIDTH-1];
          end
          ModeShr: begin
            out_d  = {rightshift, out_q[WIDTH-1:1]};
            sout_d = out_q[0];
          end
`ifdef SHIFTREG_ROTATE_EN
          ModeRol: begin
            out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            sout_d = out_q[WIDTH-1];
          end
          ModeRor: begin
            out_d  = {out_q[0], out_q[WIDTH-1:1]};
            sout_d = out_q[0];
          end
`endif
          ModeAsr: begin
            out_d  = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
            sout_d = out_q[0];
          end
          default: begin
            out_d  = out_q;
            sout_d = sout_q;
          end
        endcase
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= StIdle;
      mode_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      sout_q  <= sout_d;
    end
  end

  assign out  = out_q;
  assign sout = sout_q;
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_param_universal_shiftreg.sv
// Directed bench for param_universal_shiftreg (WIDTH=4, AMT_W=3); rotate or rotate-disabled
// vectors are chosen by SHIFTREG_ROTATE_EN to match the RTL build.
module tb_param_universal_shiftreg;

  logic       clk;
  logic       sync_reset;
  logic       start;
  logic [2:0] mode;
  logic [2:0] amount;
  logic [3:0] in;
  logic       rightshift;
  logic       leftshift;
  logic [3:0] out;
  logic       sout;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  param_universal_shiftreg #(
    .WIDTH(4),
    .AMT_W(3)
  ) u_dut (
    .clk       (clk),
    .sync_reset(sync_reset),
    .start     (start),
    .mode      (mode),
    .amount    (amount),
    .in        (in),
    .rightshift(rightshift),
    .leftshift (leftshift),
    .out       (out),
    .sout      (sout),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] val);
    start = 1'b1;
    mode  = 3'b011;
    in    = val;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    sync_reset = 1'b1;
    start      = 1'b0;
    mode       = 3'b000;
    amount     = 3'd0;
    in         = 4'b0000;
    rightshift = 1'b0;
    leftshift  = 1'b0;
    tick();
    tick();
    check("rst_out", 8'(out), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_done", 8'(done), 8'h0);
    check("rst_sout", 8'(sout), 8'h0);
    sync_reset = 1'b0;

    // Parallel load completes on the start edge.
    start = 1'b1;
    mode  = 3'b011;
    in    = 4'b1011;
    tick();
    start = 1'b0;
    check("ld_out", 8'(out), 8'hb);
    check("ld_done", 8'(done), 8'h1);
    check("ld_busy", 8'(busy), 8'h0);
    tick();
    check("ld_done_off", 8'(done), 8'h0);
    check("ld_hold", 8'(out), 8'hb);

    // Shift right x2 with rightshift=1; mode/amount/in disturbed mid-operation.
    start      = 1'b1;
    mode       = 3'b010;
    amount     = 3'd2;
    rightshift = 1'b1;
    tick();
    start  = 1'b0;
    mode   = 3'b001;
    amount = 3'd7;
    in     = 4'b0000;
    check("shr_busy0", 8'(busy), 8'h1);
    check("shr_out0", 8'(out), 8'hb);
    tick();
    check("shr_out1", 8'(out), 8'hd);
    check("shr_sout1", 8'(sout), 8'h1);
    check("shr_busy1", 8'(busy), 8'h1);
    tick();
    check("shr_out2", 8'(out), 8'he);
    check("shr_sout2", 8'(sout), 8'h1);
    check("shr_busy2", 8'(busy), 8'h0);
    check("shr_done", 8'(done), 8'h1);
    tick();
    check("shr_done_off", 8'(done), 8'h0);
    rightshift = 1'b0;

    load(4'b1011);
`ifdef SHIFTREG_ROTATE_EN
    start  = 1'b1;
    mode   = 3'b100;
    amount = 3'd3;
    tick();
    start = 1'b0;
    tick();
    check("rol_out1", 8'(out), 8'h7);
    check("rol_sout1", 8'(sout), 8'h1);
    tick();
    check("rol_out2", 8'(out), 8'he);
    check("rol_sout2", 8'(sout), 8'h0);
    tick();
    check("rol_out3", 8'(out), 8'hd);
    check("rol_sout3", 8'(sout), 8'h1);
    check("rol_done", 8'(done), 8'h1);
    tick();
    load(4'b1011);
    start  = 1'b1;
    mode   = 3'b101;
    amount = 3'd1;
    tick();
    start = 1'b0;
    tick();
    check("ror_out", 8'(out), 8'hd);
    check("ror_sout", 8'(sout), 8'h1);
    tick();
`else
    start  = 1'b1;
    mode   = 3'b101;
    amount = 3'd2;
    tick();
    start = 1'b0;
    check("norot_busy", 8'(busy), 8'h0);
    check("norot_done", 8'(done), 8'h1);
    check("norot_out", 8'(out), 8'hb);
    tick();
    check("norot_busy2", 8'(busy), 8'h0);
    check("norot_done_off", 8'(done), 8'h0);
    check("norot_out2", 8'(out), 8'hb);
`endif

    load(4'b1011);
    // Arithmetic shift right replicates the MSB.
    start  = 1'b1;
    mode   = 3'b110;
    amount = 3'd2;
    tick();
    start = 1'b0;
    tick();
    check("asr_out1", 8'(out), 8'hd);
    tick();
    check("asr_out2", 8'(out), 8'he);
    check("asr_sout2", 8'(sout), 8'h1);
    check("asr_done", 8'(done), 8'h1);
    tick();

    // amount=0 in a step mode behaves as hold.
    start  = 1'b1;
    mode   = 3'b001;
    amount = 3'd0;
    tick();
    start = 1'b0;
    check("amt0_busy", 8'(busy), 8'h0);
    check("amt0_done", 8'(done), 8'h1);
    check("amt0_out", 8'(out), 8'he);
    tick();
    check("amt0_done_off", 8'(done), 8'h0);

    // Shift left x2 from 1110 while start stays high requesting a load: must be ignored.
    start     = 1'b1;
    mode      = 3'b001;
    amount    = 3'd2;
    leftshift = 1'b0;
    tick();
    mode = 3'b011;
    in   = 4'b0000;
    tick();
    check("shl_out1", 8'(out), 8'hc);
    check("shl_sout1", 8'(sout), 8'h1);
    tick();
    check("shl_out2", 8'(out), 8'h8);
    check("shl_done", 8'(done), 8'h1);
    tick();
    start = 1'b0;
    check("ign_out", 8'(out), 8'h8);
    check("ign_busy", 8'(busy), 8'h0);
    check("ign_done", 8'(done), 8'h0);

    // leftshift sampled live per step.
    start     = 1'b1;
    mode      = 3'b001;
    amount    = 3'd2;
    leftshift = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("live_out1", 8'(out), 8'h1);
    leftshift = 1'b0;
    tick();
    check("live_out2", 8'(out), 8'h2);
    check("live_sout2", 8'(sout), 8'h0);
    tick();

    // Reset during the 2nd cycle of a 4-step shift aborts without a done pulse.
    load(4'b1011);
    start      = 1'b1;
    mode       = 3'b010;
    amount     = 3'd4;
    rightshift = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("abort_pre", 8'(out), 8'h5);
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    check("abort_out", 8'(out), 8'h0);
    check("abort_busy", 8'(busy), 8'h0);
    check("abort_done", 8'(done), 8'h0);
    check("abort_sout", 8'(sout), 8'h0);
    tick();
    check("abort_nodone", 8'(done), 8'h0);
    start = 1'b1;
    mode  = 3'b011;
    in    = 4'b0110;
    tick();
    start = 1'b0;
    check("post_abort_out", 8'(out), 8'h6);
    check("post_abort_done", 8'(done), 8'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
